// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - Gray/binary helpers and pointer type for async_fifo_param
`define FIFO_PTR_T(AW) logic [(AW):0]

package fifo_pkg;

  localparam int DEFAULT_ADDR_W = 5;
  localparam int DEFAULT_DEPTH  = 2 ** DEFAULT_ADDR_W;

  // Helpers work on a wide code word; callers zero-extend and truncate.
  localparam int CODE_W = 32;
  typedef logic [CODE_W-1:0] code_t;

  function automatic code_t bin2gray(input code_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic code_t gray2bin(input code_t gray);
    code_t bin;
    bin = gray;
    for (int i = CODE_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// rtl/ptr_sync.sv - N-flop synchroniser for Gray pointers crossing clock domains
module ptr_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_d [STAGES];
  logic [WIDTH-1:0] stage_q [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/async_fifo_param.sv
// rtl/async_fifo_param.sv - parametrised dual-clock FIFO with Gray pointer crossing
module async_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int AFULL_THR   = 28,
  parameter int AEMPTY_THR  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wr_clk,
  input  logic              rd_clk,
  input  logic              reset_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              underflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PTR_W = ADDR_W + 1;

  typedef `FIFO_PTR_T(ADDR_W) ptr_t;

  // Full when the write Gray pointer is one lap ahead: top two bits inverted.
  localparam ptr_t FULL_MASK = ptr_t'(3) << (ADDR_W - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  ptr_t wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d, rd_gray_s, rd_bin_s;
  logic full_q, full_d, overflow_q, overflow_d, wr_en;

  ptr_t rd_bin_q, rd_bin_d, rd_gray_q, rd_gray_d, wr_gray_s, wr_bin_s;
  logic empty_q, empty_d, underflow_q, underflow_d, rd_en;

  ptr_sync #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_rd2wr_sync (
    .clk     (wr_clk),
    .reset_n (reset_n),
    .d       (rd_gray_q),
    .q       (rd_gray_s)
  );

  ptr_sync #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_wr2rd_sync (
    .clk     (rd_clk),
    .reset_n (reset_n),
    .d       (wr_gray_q),
    .q       (wr_gray_s)
  );

  always_comb begin
    wr_en      = wr & ~full_q;
    wr_bin_d   = wr_bin_q + ptr_t'(wr_en);
    wr_gray_d  = ptr_t'(bin2gray(code_t'(wr_bin_d)));
    full_d     = (wr_gray_d == (rd_gray_s ^ FULL_MASK));
    overflow_d = overflow_q | (wr & full_q);
  end

  always_ff @(posedge wr_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bin_q   <= '0;
      wr_gray_q  <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_bin_q   <= wr_bin_d;
      wr_gray_q  <= wr_gray_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge wr_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_bin_q[ADDR_W-1:0]] <= data_in;
    end
  end

  always_comb begin
    rd_en       = rd & ~empty_q;
    rd_bin_d    = rd_bin_q + ptr_t'(rd_en);
    rd_gray_d   = ptr_t'(bin2gray(code_t'(rd_bin_d)));
    empty_d     = (rd_gray_d == wr_gray_s);
    underflow_d = underflow_q | (rd & empty_q);
  end

  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_bin_q    <= '0;
      rd_gray_q   <= '0;
      empty_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      rd_bin_q    <= rd_bin_d;
      rd_gray_q   <= rd_gray_d;
      empty_q     <= empty_d;
      underflow_q <= underflow_d;
    end
  end

  // Levels use the stale synchronised far pointer, so each side errs safe.
  assign rd_bin_s = ptr_t'(gray2bin(code_t'(rd_gray_s)));
  assign wr_bin_s = ptr_t'(gray2bin(code_t'(wr_gray_s)));

  assign wr_level     = wr_bin_q - rd_bin_s;
  assign rd_level     = wr_bin_s - rd_bin_q;
  assign almost_full  = (wr_level >= ptr_t'(AFULL_THR));
  assign almost_empty = (rd_level <= ptr_t'(AEMPTY_THR));
  assign full         = full_q;
  assign empty        = empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign data_out     = mem[rd_bin_q[ADDR_W-1:0]];

endmodule

// File: tb/tb_async_fifo_param.sv
// tb/tb_async_fifo_param.sv - randomized self-checking bench for async_fifo_param
module tb_async_fifo_param;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int SYNC  = 2;
  localparam int AFULL = 28;
  localparam int AEMPT = 4;

  logic          wr_clk, rd_clk, reset_n;
  logic          wr, rd;
  logic [DW-1:0] data_in, data_out;
  logic          full, almost_full, overflow;
  logic          empty, almost_empty, underflow;
  logic [AW:0]   wr_level, rd_level;

  int n_checks = 0;
  int n_pass   = 0;
  int rd_half  = 135;

  logic [DW-1:0] model_q [$];

  async_fifo_param #(
    .DATA_W(DW), .ADDR_W(AW), .AFULL_THR(AFULL), .AEMPTY_THR(AEMPT), .SYNC_STAGES(SYNC)
  ) dut (
    .wr_clk(wr_clk), .rd_clk(rd_clk), .reset_n(reset_n),
    .wr(wr), .data_in(data_in), .full(full), .almost_full(almost_full),
    .wr_level(wr_level), .overflow(overflow),
    .rd(rd), .data_out(data_out), .empty(empty), .almost_empty(almost_empty),
    .rd_level(rd_level), .underflow(underflow)
  );

  initial begin
    wr_clk = 1'b0;
    forever #50 wr_clk = ~wr_clk;
  end

  initial begin
    rd_clk = 1'b0;
    forever #(rd_half) rd_clk = ~rd_clk;
  end

  task automatic reset_dut();
    wr = 1'b0; rd = 1'b0; data_in = '0;
    reset_n = 1'b0;
    model_q.delete();
    #230;
    reset_n = 1'b1;
    @(posedge wr_clk); #10;
  endtask

  task automatic wr_push(input logic [DW-1:0] d);
    data_in = d; wr = 1'b1;
    @(posedge wr_clk); #10;
    wr = 1'b0;
  endtask

  task automatic rd_pop();
    rd = 1'b1;
    @(posedge rd_clk); #10;
    rd = 1'b0;
  endtask

  task automatic rd_wait(input int n);
    repeat (n) @(posedge rd_clk);
    #10;
  endtask

  task automatic wr_wait(input int n);
    repeat (n) @(posedge wr_clk);
    #10;
  endtask

  task automatic test_reset();
    reset_dut();
    n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty); else n_pass++;
    n_checks++; if (almost_empty !== 1'b1) $display("FAIL reset_aempty: got %b expected 1", almost_empty); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b expected 0", full); else n_pass++;
    n_checks++; if (almost_full !== 1'b0) $display("FAIL reset_afull: got %b expected 0", almost_full); else n_pass++;
    n_checks++; if (data_out !== 8'h00) $display("FAIL reset_data: got %h expected 00", data_out); else n_pass++;
    n_checks++; if (wr_level !== 6'd0) $display("FAIL reset_wr_level: got %0d expected 0", wr_level); else n_pass++;
    n_checks++; if (rd_level !== 6'd0) $display("FAIL reset_rd_level: got %0d expected 0", rd_level); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
    n_checks++; if (underflow !== 1'b0) $display("FAIL reset_underflow: got %b expected 0", underflow); else n_pass++;
  endtask

  task automatic test_fill();
    for (int k = 1; k <= DEPTH; k++) begin
      wr_push(8'(k - 1));
      n_checks++; if (wr_level !== 6'(k)) $display("FAIL fill_wr_level[%0d]: got %0d expected %0d", k, wr_level, k); else n_pass++;
      n_checks++; if (almost_full !== (k >= AFULL)) $display("FAIL fill_afull[%0d]: got %b expected %b", k, almost_full, k >= AFULL); else n_pass++;
      n_checks++; if (full !== (k == DEPTH)) $display("FAIL fill_full[%0d]: got %b expected %b", k, full, k == DEPTH); else n_pass++;
    end
    wr_push(8'hEE);
    n_checks++; if (overflow !== 1'b1) $display("FAIL fill_overflow: got %b expected 1", overflow); else n_pass++;
    n_checks++; if (wr_level !== 6'd32) $display("FAIL fill_overflow_level: got %0d expected 32", wr_level); else n_pass++;
    n_checks++; if (full !== 1'b1) $display("FAIL fill_overflow_full: got %b expected 1", full); else n_pass++;
  endtask

  task automatic test_drain();
    rd_wait(SYNC + 2);
    n_checks++; if (rd_level !== 6'd32) $display("FAIL drain_start_level: got %0d expected 32", rd_level); else n_pass++;
    n_checks++; if (empty !== 1'b0) $display("FAIL drain_start_empty: got %b expected 0", empty); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (data_out !== 8'(i)) $display("FAIL drain_data[%0d]: got %h expected %h", i, data_out, 8'(i)); else n_pass++;
      rd_pop();
      n_checks++; if (rd_level !== 6'(DEPTH - 1 - i)) $display("FAIL drain_rd_level[%0d]: got %0d expected %0d", i, rd_level, DEPTH - 1 - i); else n_pass++;
      n_checks++; if (almost_empty !== (DEPTH - 1 - i <= AEMPT)) $display("FAIL drain_aempty[%0d]: got %b expected %b", i, almost_empty, DEPTH - 1 - i <= AEMPT); else n_pass++;
    end
    n_checks++; if (empty !== 1'b1) $display("FAIL drain_empty: got %b expected 1", empty); else n_pass++;
    rd_pop();
    n_checks++; if (underflow !== 1'b1) $display("FAIL drain_underflow: got %b expected 1", underflow); else n_pass++;
    n_checks++; if (rd_level !== 6'd0) $display("FAIL drain_underflow_level: got %0d expected 0", rd_level); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL drain_underflow_empty: got %b expected 1", empty); else n_pass++;
    wr_wait(SYNC + 2);
    n_checks++; if (wr_level !== 6'd0) $display("FAIL drain_wr_level: got %0d expected 0", wr_level); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL drain_full: got %b expected 0", full); else n_pass++;
  endtask

  task automatic test_latency();
    reset_dut();
    data_in = 8'hA5; wr = 1'b1;
    @(posedge wr_clk);
    fork
      begin #10; wr = 1'b0; end
    join_none
    for (int e = 1; e <= SYNC + 1; e++) begin
      @(posedge rd_clk); #10;
      n_checks++; if (empty !== (e <= SYNC)) $display("FAIL latency_empty[%0d]: got %b expected %b", e, empty, e <= SYNC); else n_pass++;
    end
    n_checks++; if (data_out !== 8'hA5) $display("FAIL latency_data: got %h expected a5", data_out); else n_pass++;
    n_checks++; if (rd_level !== 6'd1) $display("FAIL latency_rd_level: got %0d expected 1", rd_level); else n_pass++;
  endtask

  task automatic test_random();
    int sent, got;
    reset_dut();
    sent = 0; got = 0;
    fork
      begin : writer
        int guard;
        logic [DW-1:0] d;
        guard = 0;
        while (sent < 1000 && guard < 40000) begin
          guard++;
          if (!full && $urandom_range(0, 2) != 0) begin
            d = DW'($urandom);
            model_q.push_back(d);
            wr_push(d);
            sent++;
          end else begin
            wr_wait(1);
          end
          n_checks++; if (wr_level > 6'(DEPTH)) $display("FAIL rand_wr_level: got %0d expected <= 32", wr_level); else n_pass++;
        end
      end
      begin : reader
        int guard;
        logic [DW-1:0] exp_d;
        guard = 0;
        rd_wait(1);
        while (got < 1000 && guard < 30000) begin
          guard++;
          if (!empty && $urandom_range(0, 1) != 0) begin
            if (model_q.size() == 0) begin
              n_checks++; $display("FAIL rand_phantom: got data %h expected empty model", data_out);
            end else begin
              exp_d = model_q.pop_front();
              n_checks++; if (data_out !== exp_d || $isunknown(data_out)) $display("FAIL rand_data[%0d]: got %h expected %h", got, data_out, exp_d); else n_pass++;
            end
            rd_pop();
            got++;
          end else begin
            rd_wait(1);
          end
          n_checks++; if (rd_level > 6'(DEPTH)) $display("FAIL rand_rd_level: got %0d expected <= 32", rd_level); else n_pass++;
        end
      end
    join
    n_checks++; if (sent != 1000) $display("FAIL rand_sent: got %0d expected 1000", sent); else n_pass++;
    n_checks++; if (got != 1000) $display("FAIL rand_received: got %0d expected 1000", got); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL rand_overflow: got %b expected 0", overflow); else n_pass++;
    n_checks++; if (underflow !== 1'b0) $display("FAIL rand_underflow: got %b expected 0", underflow); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp_d;
    rd_half = 50;
    reset_dut();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < DEPTH; i++) begin
        exp_d = DW'($urandom);
        model_q.push_back(exp_d);
        wr_push(exp_d);
      end
      n_checks++; if (full !== 1'b1) $display("FAIL wrap_full[%0d]: got %b expected 1", c, full); else n_pass++;
      rd_wait(SYNC + 2);
      n_checks++; if (rd_level !== 6'd32) $display("FAIL wrap_rd_level_full[%0d]: got %0d expected 32", c, rd_level); else n_pass++;
      for (int i = 0; i < DEPTH; i++) begin
        exp_d = model_q.pop_front();
        n_checks++; if (data_out !== exp_d) $display("FAIL wrap_data[%0d.%0d]: got %h expected %h", c, i, data_out, exp_d); else n_pass++;
        rd_pop();
      end
      n_checks++; if (empty !== 1'b1) $display("FAIL wrap_empty[%0d]: got %b expected 1", c, empty); else n_pass++;
      n_checks++; if (rd_level !== 6'd0) $display("FAIL wrap_rd_level[%0d]: got %0d expected 0", c, rd_level); else n_pass++;
      wr_wait(SYNC + 2);
      n_checks++; if (wr_level !== 6'd0) $display("FAIL wrap_wr_level[%0d]: got %0d expected 0", c, wr_level); else n_pass++;
      n_checks++; if (full !== 1'b0) $display("FAIL wrap_not_full[%0d]: got %b expected 0", c, full); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    rd_wait(1);
    rd_pop();
    wr_wait(1);
    for (int i = 0; i <= DEPTH; i++) wr_push(8'(8'h40 + i));
    rd_wait(SYNC + 2);
    for (int i = 0; i < DEPTH - 10; i++) rd_pop();
    n_checks++; if (rd_level !== 6'd10) $display("FAIL mid_pre_level: got %0d expected 10", rd_level); else n_pass++;
    n_checks++; if (overflow !== 1'b1 || underflow !== 1'b1) $display("FAIL mid_pre_errors: got %b%b expected 11", overflow, underflow); else n_pass++;
    #23;
    reset_n = 1'b0;
    #10;
    n_checks++; if (empty !== 1'b1) $display("FAIL mid_empty: got %b expected 1", empty); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL mid_full: got %b expected 0", full); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL mid_overflow: got %b expected 0", overflow); else n_pass++;
    n_checks++; if (underflow !== 1'b0) $display("FAIL mid_underflow: got %b expected 0", underflow); else n_pass++;
    n_checks++; if (rd_level !== 6'd0) $display("FAIL mid_rd_level: got %0d expected 0", rd_level); else n_pass++;
    n_checks++; if (data_out !== 8'h00) $display("FAIL mid_data: got %h expected 00", data_out); else n_pass++;
    #57;
    reset_n = 1'b1;
    wr_wait(1);
    wr_push(8'h3C);
    rd_wait(SYNC + 2);
    n_checks++; if (empty !== 1'b0) $display("FAIL mid_post_empty: got %b expected 0", empty); else n_pass++;
    n_checks++; if (data_out !== 8'h3C) $display("FAIL mid_post_data: got %h expected 3c", data_out); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_latency();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/async_fifo_param.md
Name: async_fifo_param

Overview:
- Parametrised dual-clock FIFO; next generation of the team's 32x8 FIFO.
- Adds configurable width/depth, Gray-coded pointer synchronisation between wr_clk and rd_clk domains, almost-full/almost-empty thresholds, per-domain fill levels and sticky overflow/underflow error flags.
- Sits between independently clocked producer and consumer blocks (e.g. UART/packet front ends).

Parameters:
- DATA_W, 8, data word width in bits
- ADDR_W, 5, log2 of depth; DEPTH = 2**ADDR_W (default 32)
- AFULL_THR, 28, wr_level at or above which almost_full asserts
- AEMPTY_THR, 4, rd_level at or below which almost_empty asserts
- SYNC_STAGES, 2, flops per pointer synchroniser (legal range 2..4)

Ports:
- wr_clk  in  1  write-domain clock
- rd_clk  in  1  read-domain clock
- reset_n  in  1  async active-low reset, both domains
- wr  in  1  write request
- data_in  in  DATA_W  write data
- full  out  1  write-domain full flag
- almost_full  out  1  wr_level >= AFULL_THR
- wr_level  out  ADDR_W+1  occupancy as seen from the write domain
- overflow  out  1  sticky: write attempted while full
- rd  in  1  read request (acknowledge of current data_out)
- data_out  out  DATA_W  show-ahead head-of-queue data
- empty  out  1  read-domain empty flag
- almost_empty  out  1  rd_level <= AEMPTY_THR
- rd_level  out  ADDR_W+1  occupancy as seen from the read domain
- underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset: reset_n is asynchronous, active-low, and is applied to both the wr_clk and rd_clk domains. All pointers, synchroniser flops, memory words, levels, overflow and underflow clear to 0. Outputs after reset: empty=1, almost_empty=1, full=0, almost_full=0, data_out=0.
- Pointers: ADDR_W+1-bit binary pointers wr_bin and rd_bin, each with a registered Gray copy (wr_gray, rd_gray). The MSB is the wrap bit. Addresses are the low ADDR_W bits.
- Write: on posedge wr_clk with wr=1 and full=0, mem[wr_bin[ADDR_W-1:0]] <= data_in and wr_bin increments (mod 2**(ADDR_W+1)). With wr=1 and full=1, memory and pointer hold and overflow <= 1.
- Read: data_out = mem[rd_bin[ADDR_W-1:0]], combinational (show-ahead, zero-latency head). On posedge rd_clk with rd=1 and empty=0, rd_bin increments. With rd=1 and empty=1, the pointer holds and underflow <= 1.
- Synchronisers: rd_gray passes through SYNC_STAGES flops on wr_clk to give rd_gray_s; wr_gray passes through SYNC_STAGES flops on rd_clk to give wr_gray_s. Only Gray values cross domains.
- full: registered, computed from the next wr_gray. Asserted when next wr_gray equals rd_gray_s with the top two bits inverted. It asserts on the same edge as the write that fills the FIFO.
- empty: registered, computed from the next rd_gray. Asserted when next rd_gray equals wr_gray_s. It asserts on the same edge as the read that drains the FIFO.
- Levels: wr_level = wr_bin - gray2bin(rd_gray_s); rd_level = gray2bin(wr_gray_s) - rd_bin. Both are ADDR_W+1-bit modular arithmetic with range 0..DEPTH. Both are pessimistic: they over-report fill in the write domain and under-report it in the read domain.
- Latency: a write becomes visible (empty deasserts) SYNC_STAGES+1 rd_clk edges after the write edge. Freed space reaches the write domain SYNC_STAGES+1 wr_clk edges after the read.
- Simultaneous wr and rd, in either domain and at any level, are legal and independent.
- Wrap-around: pointers wrap silently. The level at DEPTH is distinguished from 0 by the wrap bit.
- Reset mid-operation: contents are discarded immediately and the FIFO returns to the empty state. Errors are sticky until reset_n.

Decomposition:
- Package fifo_pkg:
  - functions bin2gray and gray2bin, parametrised by width via a typed argument;
  - localparam default DEPTH;
  - typedef ptr_t (logic [ADDR_W:0]) provided via a parametrised class or macro.
- Sub-module ptr_sync (params WIDTH, STAGES): an N-flop synchroniser with async reset. It is instantiated twice, once per crossing direction.
- The memory array stays inline as a logic [DATA_W-1:0] mem [DEPTH]. There are no hand-unrolled registers.

Test Plan:
- Reset, then 32 writes 0x00..0x1F with no reads: full=1 after the 32nd write edge, wr_level=32, almost_full from the 28th write. A 33rd write gives overflow=1 and the contents are unchanged.
- Continue from that full state with 32 reads: data_out sequence 0x00..0x1F, then empty=1. A further read gives underflow=1 and rd_bin is unchanged.
- wr_clk 100 MHz, rd_clk 37 MHz, 1000 random writes/reads with both sides throttled: scoreboard order and values exact, no X on data_out, levels never exceed 32.
- Single write 0xA5 into an empty FIFO: empty deasserts exactly 3 rd_clk edges later (SYNC_STAGES=2) and data_out=0xA5 while empty=0.
- Wrap: 3 fill/drain cycles of 32 at equal clocks: full and empty are correct across the wrap-bit flip, and wr_level/rd_level return to 0.
- Assert reset_n low with 10 entries present: the flags return immediately to empty=1 and full=0, and overflow and underflow clear. The next write after reset reads back first.
